// File: rtl/seg7_pkg.sv
// Shared 7-segment constants for active-low displays, bit order {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned SEG_DP_BIT = 7;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_E    = 8'h86;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  typedef struct packed {
    logic [15:0] bcd;
    logic        rng;
    logic        ovf;
  } disp_t;

  // Non-decimal nibbles render as 'E'.
  function automatic logic [7:0] seg_hex(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  logic [7:0] pat;

  always_comb begin
    pat   = seg_hex(nibble_i);
    seg_o = pat[6:0];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 4-digit common-anode display driver with slot-aligned loading,
// leading-zero blanking, range dp, overflow dashes and inter-digit blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bcd_num,
  input  logic        load,
  input  logic        range,
  input  logic        overflow,
  output logic [3:0]  anodes,
  output logic [7:0]  cathodes
);

  localparam int unsigned CW = $clog2(SCAN_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  disp_t         act_q, act_d, pend_q, pend_d;
  logic          pend_flag_q, pend_flag_d;
  logic [3:0]    anodes_q, anodes_d;
  logic [7:0]    cathodes_q, cathodes_d;

  logic          boundary, blank, hi_zero;
  logic [3:0]    nib;
  logic [6:0]    seg7;
  logic [7:0]    pat;
  disp_t         load_val;

  assign boundary = (cnt_q == CW'(SCAN_DIV - 1));
  assign blank    = (BLANK_CYCLES != 0) && (32'(cnt_q) < BLANK_CYCLES);
  assign load_val = '{bcd: bcd_num, rng: range, ovf: overflow};

  always_comb begin
    nib     = act_q.bcd[3:0];
    hi_zero = 1'b0;
    case (dig_q)
      2'd0: nib = act_q.bcd[3:0];
      2'd1: begin nib = act_q.bcd[7:4];   hi_zero = (act_q.bcd[15:4]  == '0); end
      2'd2: begin nib = act_q.bcd[11:8];  hi_zero = (act_q.bcd[15:8]  == '0); end
      2'd3: begin nib = act_q.bcd[15:12]; hi_zero = (act_q.bcd[15:12] == '0); end
      default: ;
    endcase
  end

  seg7_decoder u_dec (
    .nibble_i (nib),
    .seg_o    (seg7)
  );

  always_comb begin
    if (act_q.ovf)                      pat = SEG_DASH;
    else if (nib > 4'd9)                pat = {1'b1, seg7};
    else if (LZ_BLANK && hi_zero)       pat = SEG_OFF;
    else                                pat = {1'b1, seg7};
    if (dig_q == 2'd0 && act_q.rng && !act_q.ovf)
      pat[SEG_DP_BIT] = 1'b0;
  end

  // A load on the boundary cycle bypasses pending so it shows in the very next slot.
  always_comb begin
    cnt_d       = boundary ? '0 : cnt_q + 1'b1;
    dig_d       = boundary ? dig_q + 2'd1 : dig_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (load) begin
      if (boundary) begin
        act_d       = load_val;
        pend_flag_d = 1'b0;
      end else begin
        pend_d      = load_val;
        pend_flag_d = 1'b1;
      end
    end else if (boundary && pend_flag_q) begin
      act_d       = pend_q;
      pend_flag_d = 1'b0;
    end
    anodes_d   = blank ? 4'b1111 : ~(4'b0001 << dig_q);
    cathodes_d = blank ? SEG_OFF : pat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
      anodes_q    <= '1;
      cathodes_q  <= '1;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      anodes_q    <= anodes_d;
      cathodes_q  <= cathodes_d;
    end
  end

  assign anodes   = anodes_q;
  assign cathodes = cathodes_q;

endmodule
